instruction_prefetch_queue: RTL and testbench

- Fetch front end that feeds the pipelined MIPS core's IF/ID register.
- Owns the fetch PC and issues sequential word reads to a synchronous instruction ROM with 1-cycle read latency.
- Buffers returned instructions with their PC+4 in a small FIFO, so a decode stall does not lose fetched words.
- Flushes on branch/jump redirects from EX.

---
 rtl/mips_fetch_pkg.sv | 9 +
 rtl/prefetch_fifo.sv | 36 +++
 rtl/instruction_prefetch_queue.sv | 60 ++++++
 tb/tb_instruction_prefetch_queue.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared fetch constants and the queued fetch entry type
package mips_fetch_pkg;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int INSTR_W = 32;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc_plus4;
  } fetch_entry_t;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: circular buffer with synchronous flush, occupancy count and head data
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign head_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) assert (count < CNT_W'(DEPTH));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (push && !rst && !flush) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/instruction_prefetch_queue.sv
// instruction_prefetch_queue: fetch PC, ROM request admission and redirect flush around a prefetch FIFO
module instruction_prefetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = mips_fetch_pkg::RESET_PC,
  parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_redirect,
  input  logic [31:0]      i_redirect_pc_32,
  input  logic             i_stall,
  output logic             o_mem_req,
  output logic [31:0]      o_mem_addr_32,
  input  logic [31:0]      i_mem_rdata_32,
  output logic             o_valid,
  output logic [31:0]      o_instr_32,
  output logic [31:0]      o_pc_plus4_32,
  output logic [CNT_W-1:0] o_count
);
  logic [31:0] fetch_pc, issued_pc;
  logic inflight;
  logic [CNT_W-1:0] count;
  fetch_entry_t push_entry, head_entry;
  assign o_mem_req = !reset && !i_redirect &&
                     ((CNT_W+1)'(count) + (CNT_W+1)'(inflight) < (CNT_W+1)'(DEPTH));
  assign o_mem_addr_32 = fetch_pc;
  assign push_entry = '{instr: i_mem_rdata_32, pc_plus4: issued_pc + 32'd4};
  assign o_valid = count != '0;
  assign o_count = count;
  assign o_instr_32 = o_valid ? head_entry.instr : '0;
  assign o_pc_plus4_32 = o_valid ? head_entry.pc_plus4 : '0;
  prefetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(fetch_entry_t)),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk(clk),
    .rst(reset),
    .flush(i_redirect),
    .push(inflight),
    .push_data(push_entry),
    .pop(o_valid && !i_stall),
    .count(count),
    .head_data(head_entry)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= o_mem_req;
      fetch_pc <= i_redirect ? {i_redirect_pc_32[31:2], 2'b00} :
                  o_mem_req ? fetch_pc + 32'd4 : fetch_pc;
      if (o_mem_req) issued_pc <= fetch_pc;
    end
  end
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// tb_instruction_prefetch_queue: directed and randomized scoreboard check of the prefetch queue
module tb_instruction_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam logic [31:0] RPC = 32'h0040_0000;
  logic clk = 1'b0;
  logic reset, i_redirect, i_stall;
  logic [31:0] i_redirect_pc_32, i_mem_rdata_32;
  logic o_mem_req, o_valid;
  logic [31:0] o_mem_addr_32, o_instr_32, o_pc_plus4_32;
  logic [CNT_W-1:0] o_count;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;
  logic [31:0] mon_pc;
  bit ok;
  always #5 clk = ~clk;
  instruction_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .i_redirect(i_redirect),
    .i_redirect_pc_32(i_redirect_pc_32),
    .i_stall(i_stall),
    .o_mem_req(o_mem_req),
    .o_mem_addr_32(o_mem_addr_32),
    .i_mem_rdata_32(i_mem_rdata_32),
    .o_valid(o_valid),
    .o_instr_32(o_instr_32),
    .o_pc_plus4_32(o_pc_plus4_32),
    .o_count(o_count)
  );
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + ((a - RPC) >> 2);
  endfunction
  always @(posedge clk) i_mem_rdata_32 <= o_mem_req ? rom(o_mem_addr_32) : $urandom;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    next_pc = {pc[31:2], 2'b00};
  endtask
  task automatic drive(input logic r, input logic rd, input logic [31:0] tgt, input logic st);
    reset = r;
    i_redirect = rd;
    i_redirect_pc_32 = tgt;
    i_stall = st;
    if (r) restart(RPC);
    else if (rd) restart(tgt);
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_pc);
      next_pc += 32'd4;
    end
  endtask
  task automatic cyc(input logic r, input logic rd, input logic [31:0] tgt, input logic st);
    @(posedge clk);
    #1;
    drive(r, rd, tgt, st);
    #3;
  endtask
  task automatic wait_count(input int n, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 8 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (o_count == CNT_W'(n)) hit = 1'b1;
      else begin
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_count: o_count=%0d never reached %0d", o_count, n);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (o_valid && !i_stall && !i_redirect) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: delivered pc_plus4 %h with no expected entry", o_pc_plus4_32);
        end else begin
          checks--;
          mon_pc = exp_q.pop_front();
          chk("instr", o_instr_32, rom(mon_pc));
          chk("pc_plus4", o_pc_plus4_32, mon_pc + 32'd4);
        end
      end
      if (!o_valid) begin
        chk("idle_instr", o_instr_32, 32'h0);
        chk("idle_pc_plus4", o_pc_plus4_32, 32'h0);
      end
      if (o_count >= CNT_W'(DEPTH)) chk("full_no_req", {31'b0, o_mem_req}, 32'h0);
    end
  end
  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst_valid", {31'b0, o_valid}, 32'h0);
    chk("rst_req", {31'b0, o_mem_req}, 32'h0);
    chk("rst_count", 32'(o_count), 32'h0);
    chk("rst_instr", o_instr_32, 32'h0);
    chk("rst_pc_plus4", o_pc_plus4_32, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("c0_req", {31'b0, o_mem_req}, 32'h1);
    chk("c0_addr", o_mem_addr_32, RPC);
    chk("c0_valid", {31'b0, o_valid}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("c1_valid", {31'b0, o_valid}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("c2_valid", {31'b0, o_valid}, 32'h1);
    chk("c2_instr", o_instr_32, 32'h1000_0000);
    chk("c2_pc_plus4", o_pc_plus4_32, 32'h0040_0004);
    repeat (5) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (8) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("full_count", 32'(o_count), 32'd4);
    chk("full_req", {31'b0, o_mem_req}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("first_pop_no_req", {31'b0, o_mem_req}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("resume_req", {31'b0, o_mem_req}, 32'h1);
    repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    wait_count(3, ok);
    drive(1'b0, 1'b1, 32'h0040_0100, 1'b0);
    #3;
    chk("redir_no_req", {31'b0, o_mem_req}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_count", 32'(o_count), 32'h0);
    chk("redir_req", {31'b0, o_mem_req}, 32'h1);
    chk("redir_addr", o_mem_addr_32, 32'h0040_0100);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_n2_valid", {31'b0, o_valid}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_n3_valid", {31'b0, o_valid}, 32'h1);
    chk("redir_n3_pc_plus4", o_pc_plus4_32, 32'h0040_0104);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0040_0103, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("align_addr", o_mem_addr_32, 32'h0040_0100);
    repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0040_0200, 1'b0);
    cyc(1'b0, 1'b1, 32'h0040_0300, 1'b0);
    chk("b2b_count", 32'(o_count), 32'h0);
    chk("b2b_no_req", {31'b0, o_mem_req}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("b2b_addr", o_mem_addr_32, 32'h0040_0300);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("b2b_valid", {31'b0, o_valid}, 32'h1);
    chk("b2b_pc_plus4", o_pc_plus4_32, 32'h0040_0304);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    wait_count(3, ok);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    #3;
    chk("mid_rst_req", {31'b0, o_mem_req}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mid_rst_valid", {31'b0, o_valid}, 32'h0);
    chk("mid_rst_count", 32'(o_count), 32'h0);
    chk("mid_rst_instr", o_instr_32, 32'h0);
    chk("mid_rst_pc_plus4", o_pc_plus4_32, 32'h0);
    chk("mid_rst_addr", o_mem_addr_32, RPC);
    repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 24) == 0,
          ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                      : RPC + $urandom_range(0, 1023),
          $urandom_range(0, 99) < 35);
    end
    repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
